// File: rtl/bus_pkg.sv
`default_nettype none
// ============================================================================
// Module : bus_pkg
// Brief  : Shared constants and FSM encoding for the wired-OR datapath bus.
// Rev    : 1.0  initial release
// ============================================================================
package bus_pkg;

    localparam int BUS_SRCS = 16;
    localparam int BUS_W    = 32;
    localparam int ID_W     = 4;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_t;

endpackage : bus_pkg
`default_nettype wire

// File: rtl/bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module : bus_arbiter_if
// Brief  : Request/grant and lane-gating bundle between sources and arbiter.
// Rev    : 1.0  initial release
// ============================================================================
interface bus_arbiter_if #(
    parameter int N = bus_pkg::BUS_SRCS,
    parameter int W = bus_pkg::BUS_W
) ();

    logic [N-1:0]             req;
    logic [N-1:0]             last;
    logic [N*W-1:0]           data_in;
    logic [N*W-1:0]           drive_out;
    logic [N-1:0]             gnt;
    logic [bus_pkg::ID_W-1:0] gnt_id;
    logic                     bus_busy;
    logic                     hold_timeout;

    // Arbiter side
    modport slave (
        input  req, last, data_in,
        output drive_out, gnt, gnt_id, bus_busy, hold_timeout
    );

    // Source side
    modport master (
        output req, last, data_in,
        input  drive_out, gnt, gnt_id, bus_busy, hold_timeout
    );

endinterface : bus_arbiter_if
`default_nettype wire

// File: rtl/bus_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module : rr_pick
// Brief  : Combinational round-robin picker; first eligible requester found
//          scanning upward from the pointer, wrapping N-1 -> 0.
// Rev    : 1.0  initial release
// ============================================================================
module rr_pick
    import bus_pkg::*;
#(
    parameter int N = BUS_SRCS
) (
    input  logic [N-1:0]    req_i,
    input  logic [ID_W-1:0] ptr_i,
    input  logic [N-1:0]    excl_i,
    output logic [N-1:0]    pick_o,
    output logic [ID_W-1:0] idx_o,
    output logic            valid_o
);

    logic [N-1:0]  w_cand;
    logic [ID_W:0] w_sum;

    assign w_cand = req_i & ~excl_i;

    always_comb begin
        pick_o  = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        w_sum   = '0;
        for (int i = 0; i < N; i++) begin
            w_sum = {1'b0, ptr_i} + (ID_W+1)'(i);
            if (w_sum >= (ID_W+1)'(N)) begin
                w_sum = w_sum - (ID_W+1)'(N);
            end
            if (!valid_o && w_cand[w_sum[ID_W-1:0]]) begin
                valid_o                   = 1'b1;
                pick_o[w_sum[ID_W-1:0]]   = 1'b1;
                idx_o                     = w_sum[ID_W-1:0];
            end
        end
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module : bus_arbiter
// Brief  : Round-robin source arbiter for the wired-OR datapath bus; grants
//          one source at a time and zeroes every ungranted lane.
// Rev    : 1.0  initial release
// ============================================================================
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int N        = BUS_SRCS,
    parameter int W        = BUS_W,
    parameter int MAX_HOLD = 8
) (
    input  logic          clk,
    input  logic          reset,
    bus_arbiter_if.slave  bus
);

    arb_state_t      state_q, state_d;
    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [N-1:0]    gnt_q, gnt_d;
    logic [ID_W-1:0] gnt_id_q, gnt_id_d;
    logic            hto_q, hto_d;

    logic [ID_W-1:0] w_next_ptr;
    logic [ID_W-1:0] w_pick_ptr;
    logic [N-1:0]    w_excl;
    logic [N-1:0]    w_pick;
    logic [ID_W-1:0] w_pick_idx;
    logic            w_pick_valid;
    logic            w_timeout;
    logic            w_release;

    assign w_next_ptr = (gnt_id_q == ID_W'(N-1)) ? '0 : gnt_id_q + 1'b1;

    // While granted, the picker already looks past the current owner so a
    // release can hand over in the same edge without an idle bubble.
    assign w_pick_ptr = (state_q == ST_GRANT) ? w_next_ptr : ptr_q;
    assign w_excl     = (state_q == ST_GRANT) ? gnt_q : '0;

    rr_pick #(.N(N)) u_pick (
        .req_i   (bus.req),
        .ptr_i   (w_pick_ptr),
        .excl_i  (w_excl),
        .pick_o  (w_pick),
        .idx_o   (w_pick_idx),
        .valid_o (w_pick_valid)
    );

    assign w_timeout = (cnt_q == 8'(MAX_HOLD));
    assign w_release = !bus.req[gnt_id_q] || bus.last[gnt_id_q] || w_timeout;

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        gnt_d    = gnt_q;
        gnt_id_d = gnt_id_q;
        hto_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (w_pick_valid) begin
                    state_d  = ST_GRANT;
                    gnt_d    = w_pick;
                    gnt_id_d = w_pick_idx;
                    cnt_d    = 8'd1;
                end
            end
            ST_GRANT: begin
                if (w_release) begin
                    hto_d = w_timeout;
                    ptr_d = w_next_ptr;
                    if (w_pick_valid) begin
                        gnt_d    = w_pick;
                        gnt_id_d = w_pick_idx;
                        cnt_d    = 8'd1;
                    end else begin
                        state_d  = ST_IDLE;
                        gnt_d    = '0;
                        gnt_id_d = '0;
                        cnt_d    = 8'd0;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                gnt_d    = '0;
                gnt_id_d = '0;
                cnt_d    = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            cnt_q    <= 8'd0;
            gnt_q    <= '0;
            gnt_id_q <= '0;
            hto_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            gnt_q    <= gnt_d;
            gnt_id_q <= gnt_id_d;
            hto_q    <= hto_d;
        end
    end

    assign bus.gnt          = gnt_q;
    assign bus.gnt_id       = gnt_id_q;
    assign bus.bus_busy     = (state_q == ST_GRANT);
    assign bus.hold_timeout = hto_q;

    // Lane gating keeps the OR-combined bus equal to the owner's data alone
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_lane
            assign bus.drive_out[gi*W +: W] = bus.data_in[gi*W +: W] & {W{gnt_q[gi]}};
        end
    endgenerate

endmodule : bus_arbiter
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_bus_arbiter
// Brief  : Directed and random scoreboard bench for bus_arbiter.
// Rev    : 1.0  initial release
// ============================================================================
module tb_bus_arbiter;
    import bus_pkg::*;

    localparam int N        = 16;
    localparam int W        = 32;
    localparam int MAX_HOLD = 8;
    localparam int WAIT_MAX = (N-1)*MAX_HOLD + N;

    typedef struct packed {
        logic [N-1:0]    gnt;
        logic [ID_W-1:0] id;
        logic            busy;
        logic            hto;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bus_arbiter_if #(.N(N), .W(W)) bif ();

    bus_arbiter #(.N(N), .W(W), .MAX_HOLD(MAX_HOLD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif.slave)
    );

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    // Reference model state
    bit   m_busy  = 1'b0;
    int   m_owner = 0;
    int   m_ptr   = 0;
    int   m_cnt   = 0;
    int   wait_cnt[N];
    int   max_wait = 0;

    task automatic chk(input string tag, input logic [N*W-1:0] obs, input logic [N*W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_next(input logic rst, input logic [N-1:0] r, input logic [N-1:0] l,
                              output exp_t e);
        bit to;
        bit found;
        int c;
        int k;
        to = 1'b0;
        if (rst) begin
            m_busy = 1'b0; m_owner = 0; m_ptr = 0; m_cnt = 0;
        end else if (!m_busy) begin
            for (int i = 0; i < N; i++) begin
                c = (m_ptr + i) % N;
                if (!m_busy && r[c]) begin
                    m_busy = 1'b1; m_owner = c; m_cnt = 1;
                end
            end
        end else begin
            to = (m_cnt == MAX_HOLD);
            if (!r[m_owner] || l[m_owner] || to) begin
                k     = m_owner;
                m_ptr = (k + 1) % N;
                found = 1'b0;
                for (int i = 0; i < N; i++) begin
                    c = (m_ptr + i) % N;
                    if (!found && c != k && r[c]) begin
                        found = 1'b1; m_owner = c; m_cnt = 1;
                    end
                end
                if (!found) begin
                    m_busy = 1'b0; m_owner = 0; m_cnt = 0;
                end
            end else begin
                m_cnt++;
            end
        end
        e.gnt  = m_busy ? (N'(1) << m_owner) : '0;
        e.id   = ID_W'(m_owner);
        e.busy = m_busy;
        e.hto  = to;
    endtask

    task automatic check_outputs(input exp_t o);
        logic [N*W-1:0] exp_drive;
        logic [W-1:0]   or_lanes;
        logic [W-1:0]   owner_data;
        exp_drive  = '0;
        or_lanes   = '0;
        owner_data = '0;
        for (int i = 0; i < N; i++) begin
            if (o.gnt[i]) begin
                exp_drive[i*W +: W] = bif.data_in[i*W +: W];
                owner_data          = bif.data_in[i*W +: W];
            end
            or_lanes = or_lanes | bif.drive_out[i*W +: W];
        end
        chk("gnt",          bif.gnt,          o.gnt);
        chk("gnt_id",       bif.gnt_id,       o.id);
        chk("bus_busy",     bif.bus_busy,     o.busy);
        chk("hold_timeout", bif.hold_timeout, o.hto);
        chk("drive_out",    bif.drive_out,    exp_drive);
        chk("onehot0",      $onehot0(bif.gnt), 1'b1);
        chk("or_bus",       or_lanes,         owner_data);
    endtask

    task automatic step(input logic rst, input logic [N-1:0] r, input logic [N-1:0] l);
        exp_t e;
        exp_t o;
        reset    = rst;
        bif.req  = r;
        bif.last = l;
        model_next(rst, r, l, e);
        sb.push_back(e);
        @(posedge clk);
        #1;
        o = sb.pop_front();
        check_outputs(o);
        for (int i = 0; i < N; i++) begin
            if (!rst && bif.req[i] && !bif.gnt[i]) wait_cnt[i]++;
            else                                   wait_cnt[i] = 0;
            if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
        end
    endtask

    task automatic rand_data();
        for (int i = 0; i < N; i++) bif.data_in[i*W +: W] = $urandom();
    endtask

    logic [N-1:0] prev_gnt;
    logic [N-1:0] hist[12];
    logic         hto_hist[12];
    int           run_len;
    int           hto_cnt;
    logic [N-1:0] rq;
    logic [N-1:0] lt;

    initial begin
        for (int i = 0; i < N; i++) wait_cnt[i] = 0;
        reset       = 1'b1;
        bif.req     = '0;
        bif.last    = '0;
        rand_data();

        // Reset state
        step(1'b1, '0, '0);
        step(1'b1, 16'h0001, '0);
        chk("rst_gnt",   bif.gnt,       '0);
        chk("rst_drive", bif.drive_out, '0);

        // Single requester, last on first beat
        bif.data_in[0 +: W] = 32'hDEADBEEF;
        step(1'b0, 16'h0001, 16'h0001);
        chk("t1_gnt",    bif.gnt,                 16'h0001);
        chk("t1_lane0",  bif.drive_out[0 +: W],   32'hDEADBEEF);
        chk("t1_others", bif.drive_out[N*W-1:W],  '0);
        step(1'b0, 16'h0001, 16'h0001);
        chk("t1_idle",   bif.gnt,                 '0);
        step(1'b0, '0, '0);

        // Two steady requesters with last: alternating grants, no bubbles
        step(1'b0, 16'h8001, 16'hFFFF);
        prev_gnt = bif.gnt;
        for (int s = 0; s < 6; s++) begin
            step(1'b0, 16'h8001, 16'hFFFF);
            chk("t2_busy", bif.bus_busy, 1'b1);
            chk("t2_alt",  bif.gnt, (prev_gnt == 16'h8000) ? 16'h0001 : 16'h8000);
            prev_gnt = bif.gnt;
        end
        step(1'b0, '0, '0);
        step(1'b0, '0, '0);

        // Hold limit on source 3
        hto_cnt = 0;
        for (int s = 0; s < 12; s++) begin
            step(1'b0, 16'h0008, '0);
            hist[s]     = bif.gnt;
            hto_hist[s] = bif.hold_timeout;
            if (bif.hold_timeout) hto_cnt++;
        end
        run_len = 0;
        for (int s = 0; s < 12; s++) begin
            if (hist[s] == 16'h0008 && run_len == s) run_len++;
        end
        chk("t3_hold_len", run_len,      8);
        chk("t3_hto_once", hto_cnt,      1);
        chk("t3_hto_at",   hto_hist[8],  1'b1);
        chk("t3_gap",      hist[8],      '0);
        chk("t3_regrant",  hist[9],      16'h0008);
        step(1'b0, '0, '0);
        step(1'b0, '0, '0);

        // Handover from 2 to 5, no preemption by source 0
        step(1'b0, 16'h0004, '0);
        chk("t4_gnt2", bif.gnt, 16'h0004);
        step(1'b0, 16'h0024, '0);
        step(1'b0, 16'h0024, '0);
        chk("t4_hold", bif.gnt, 16'h0004);
        step(1'b0, 16'h0020, '0);
        chk("t4_move", bif.gnt, 16'h0020);
        for (int s = 0; s < 3; s++) begin
            step(1'b0, 16'h0021, '0);
            chk("t4_nopreempt", bif.gnt, 16'h0020);
        end
        step(1'b0, '0, '0);
        step(1'b0, '0, '0);

        // Reset during a grant to source 7
        step(1'b0, 16'h0080, '0);
        step(1'b0, 16'h0080, '0);
        chk("t5_gnt7", bif.gnt, 16'h0080);
        step(1'b1, 16'h0080, '0);
        chk("t5_gnt",   bif.gnt,       '0);
        chk("t5_drive", bif.drive_out, '0);
        chk("t5_busy",  bif.bus_busy,  1'b0);
        step(1'b0, 16'h0081, '0);
        chk("t5_ptr0",  bif.gnt,       16'h0001);

        // Random traffic with sticky requests
        rq = '0;
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(15) == 0) rq[i] = ~rq[i];
                lt[i] = ($urandom_range(5) == 0);
            end
            rand_data();
            step(1'b0, rq, lt);
        end
        chk("max_wait_ok", (max_wait <= WAIT_MAX), 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_bus_arbiter
`default_nettype wire

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Source-side controller for the 16-way, 32-bit wired-OR datapath bus. The bus module ORs all source lanes together, so each lane must be all-zero unless its owner holds the bus.
- This block takes bus requests from up to 16 units and grants exactly one at a time, round-robin.
- It gates each unit's data onto its own lane and forces every ungranted lane to zero. The OR-combined bus therefore always carries a single clean value.

Parameters:
- N, 16, number of requesting sources (2..16).
- W, 32, data width per source lane.
- MAX_HOLD, 8, maximum beats one grant may last before a forced release (1..255).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  N  per-source bus request; bit i belongs to source i.
- last  input  N  per-source final-beat marker; sampled only for the granted source.
- data_in  input  N*W  source data; lane i is bits [i*W +: W].
- drive_out  output  N*W  gated lanes feeding the OR-bus inputs w1..wN; lane i equals data_in lane i when gnt[i]=1, else 0.
- gnt  output  N  one-hot grant, registered; all-zero when idle.
- gnt_id  output  4  index of the granted source; 0 when idle.
- bus_busy  output  1  1 while any grant is active.
- hold_timeout  output  1  one-cycle pulse when a grant is force-released at MAX_HOLD.

Behaviour:
- Reset values: gnt=0, gnt_id=0, bus_busy=0, hold_timeout=0, drive_out=0. Round-robin pointer=0, beat counter=0, state=IDLE. Reset asserted mid-grant drops the grant on the next edge; drive_out is all-zero that same cycle.
- States:
  - IDLE: no owner.
  - GRANT: one owner; beat counter cnt counts cycles spent in GRANT, starting at 1.
- IDLE -> GRANT: any req bit set at edge t gives gnt one-hot at t+1. The winner is the first requester found scanning from pointer upward, wrapping N-1 -> 0.
- Grant latency: exactly 1 cycle from req to gnt. drive_out is combinational from the registered gnt and data_in, so there is zero latency from data_in to drive_out.
- GRANT release conditions, evaluated each edge for owner k:
  - (a) req[k]=0;
  - (b) req[k]=1 and last[k]=1, where this beat is still driven;
  - (c) cnt==MAX_HOLD, which also raises hold_timeout for one cycle.
- On release:
  - pointer becomes (k+1) mod N.
  - Re-arbitration happens in the same edge using the new pointer, excluding k. If another source requests, gnt moves directly to it next cycle with no idle bubble. Otherwise the state returns to IDLE.
  - k may win again only via a later arbitration in which no other source requests. If k is the sole requester it is granted after one IDLE cycle.
- Simultaneous conditions: (b) and (c) in the same cycle count as a single release; hold_timeout still pulses.
- Requests from non-owners never preempt the current owner.
- last[i] for i≠k is ignored. last in IDLE is ignored.
- gnt is always one-hot or zero, and gnt_id always matches gnt. Checkers assert onehot0(gnt) and that the OR of all drive_out lanes equals the owner's data.
- Counter: width 8; saturation is unreachable because release occurs at MAX_HOLD. cnt is cleared on every new grant.
- For N<16, gnt_id uses its low bits and unused upper bits are 0.

Decomposition:
- Shared package bus_pkg holds: BUS_SRCS=16, BUS_W=32, ID_W=4, and the IDLE/GRANT state encoding. The bus and this block both import it.
- One sub-module, rr_pick: a combinational round-robin picker.
  - Inputs: req vector, pointer, exclude mask.
  - Outputs: one-hot pick, pick index, valid.
- The FSM, counter and lane gating stay in bus_arbiter.

Test Plan:
- Reset, then req=0x0001 with last[0]=1 on the first beat: gnt=0x0001 one cycle after req; drive_out lane0=data_in lane0 (0xDEADBEEF) and all other lanes 0; IDLE the next cycle with gnt=0.
- req=0x8001 held steadily, last=0xFFFF: grants alternate 0x0001, 0x8000, 0x0001, … with no idle cycles, and gnt_id alternates 0, 15.
- Source 3 holds req with last=0 and MAX_HOLD=8: gnt[3] stays high for exactly 8 cycles, then hold_timeout pulses once and the grant drops. With req still high, it is re-granted after one IDLE cycle.
- While source 2 is granted, assert req=0x0024 (sources 2 and 5), then source 2 drops req: gnt moves to 0x0020 on the next edge. Source 5 is never preempted mid-grant by a new req[0].
- Assert reset during a grant to source 7: gnt=0, drive_out=0, bus_busy=0 after the edge. Pointer=0, so a following req=0x0081 grants source 0 first.
- Random req/last/data for 10k cycles: gnt is onehot0 every cycle; the OR of all drive_out lanes equals the owner's data_in (or 0 when idle); no requester waits more than (N-1)*MAX_HOLD+N cycles.
